// File: rtl/simple_fifo_downsizer_pkg.sv
// rtl/simple_fifo_downsizer_pkg.sv - shared width derivations for the wide-to-narrow FIFO
package simple_fifo_downsizer_pkg;

    // Number of narrow slices carried by one wide word.
    function automatic int calc_ratio(input int in_w, input int out_w);
        return in_w / out_w;
    endfunction

    // Bits needed to index a slice within a wide word (never below 1).
    function automatic int calc_slice_idx_w(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    // Width of a slice count 0..ratio (one bit more than the slice index).
    function automatic int calc_nslices_w(input int ratio);
        return $clog2(ratio) + 1;
    endfunction

    // Slice-count width for the default 128-to-16 configuration.
    localparam int NSLICES_W_DEFAULT = calc_nslices_w(calc_ratio(128, 16));

endpackage

// File: rtl/simple_fifo_downsizer_if.sv
// rtl/simple_fifo_downsizer_if.sv - write/read bus bundle, optional SIMPLE_FIFO_DOWNSIZER_PARTIAL_EN
interface simple_fifo_downsizer_if
    import simple_fifo_downsizer_pkg::*;
#(
    parameter int DATA_IN_WIDTH  = 128,
    parameter int DATA_OUT_WIDTH = 16,
    parameter int ADDR_WIDTH     = 4
);
    localparam int RATIO     = calc_ratio(DATA_IN_WIDTH, DATA_OUT_WIDTH);
    localparam int NSLICES_W = calc_nslices_w(RATIO);

    logic                      wr_ena;
    logic [DATA_IN_WIDTH-1:0]  wr_dat;
    logic                      wr_last;
    logic                      wr_full;
    logic                      rd_ena;
    logic [DATA_OUT_WIDTH-1:0] rd_dat;
    logic                      rd_last;
    logic                      rd_empty;
    logic [ADDR_WIDTH:0]       rd_dat_cnt;
`ifdef SIMPLE_FIFO_DOWNSIZER_PARTIAL_EN
    logic [NSLICES_W-1:0]      wr_nslices;

    modport master (
        output wr_ena, wr_dat, wr_last, wr_nslices, rd_ena,
        input  wr_full, rd_dat, rd_last, rd_empty, rd_dat_cnt
    );

    modport slave (
        input  wr_ena, wr_dat, wr_last, wr_nslices, rd_ena,
        output wr_full, rd_dat, rd_last, rd_empty, rd_dat_cnt
    );
`else
    modport master (
        output wr_ena, wr_dat, wr_last, rd_ena,
        input  wr_full, rd_dat, rd_last, rd_empty, rd_dat_cnt
    );

    modport slave (
        input  wr_ena, wr_dat, wr_last, rd_ena,
        output wr_full, rd_dat, rd_last, rd_empty, rd_dat_cnt
    );
`endif

endinterface

// File: rtl/simple_fifo_downsizer_ram.sv
// rtl/simple_fifo_downsizer_ram.sv - simple dual-port array, registered write, async read
module simple_fifo_downsizer_ram #(
    parameter int WIDTH      = 129,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are never cleared; the pointer logic decides what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/simple_fifo_downsizer.sv
// rtl/simple_fifo_downsizer.sv - wide-in narrow-out FWFT FIFO, optional SIMPLE_FIFO_DOWNSIZER_PARTIAL_EN
module simple_fifo_downsizer
    import simple_fifo_downsizer_pkg::*;
#(
    parameter int DATA_IN_WIDTH  = 128,
    parameter int DATA_OUT_WIDTH = 16,
    parameter int ADDR_WIDTH     = 4,
    parameter int FULL_SLACK     = 1,
    parameter int USE_LAST       = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    simple_fifo_downsizer_if.slave bus
);
    localparam int RATIO  = calc_ratio(DATA_IN_WIDTH, DATA_OUT_WIDTH);
    localparam int SIW    = calc_slice_idx_w(RATIO);
    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int LAST_W = (USE_LAST != 0) ? 1 : 0;
`ifdef SIMPLE_FIFO_DOWNSIZER_PARTIAL_EN
    localparam int NSW    = calc_nslices_w(RATIO);
    localparam int END_W  = SIW;
`else
    localparam int END_W  = 0;
`endif
    localparam int ENTRY_W = DATA_IN_WIDTH + LAST_W + END_W;

    localparam logic [SIW-1:0]      FULL_IDX    = SIW'(RATIO - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] FULL_THRESH = (ADDR_WIDTH + 1)'(DEPTH - FULL_SLACK);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [SIW-1:0]        slice_idx_q, slice_idx_d;

    logic                     pop;
    logic                     word_done;
    logic                     wr_accept;
    logic [ENTRY_W-1:0]       wr_entry;
    logic [ENTRY_W-1:0]       rd_entry;
    logic [DATA_IN_WIDTH-1:0] head_data;
    logic                     head_last;
    logic [SIW-1:0]           head_end_idx;

    assign wr_entry[DATA_IN_WIDTH-1:0] = bus.wr_dat;
    assign head_data = rd_entry[DATA_IN_WIDTH-1:0];

    generate
        if (USE_LAST != 0) begin : g_last
            assign wr_entry[DATA_IN_WIDTH] = bus.wr_last;
            assign head_last = rd_entry[DATA_IN_WIDTH];
        end else begin : g_no_last
            assign head_last = 1'b0;
        end
    endgenerate

`ifdef SIMPLE_FIFO_DOWNSIZER_PARTIAL_EN
    logic [SIW-1:0] wr_end_idx;

    // Store the index of the final slice so the read side needs no arithmetic.
    always_comb begin
        wr_end_idx = FULL_IDX;
        if ((USE_LAST != 0) && bus.wr_last && (bus.wr_nslices != '0) &&
            (bus.wr_nslices <= NSW'(RATIO))) begin
            wr_end_idx = SIW'(bus.wr_nslices - NSW'(1));
        end
    end

    assign wr_entry[DATA_IN_WIDTH+LAST_W +: END_W] = wr_end_idx;
    assign head_end_idx = rd_entry[DATA_IN_WIDTH+LAST_W +: END_W];
`else
    assign head_end_idx = FULL_IDX;
`endif

    simple_fifo_downsizer_ram #(
        .WIDTH      (ENTRY_W),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_entry)
    );

    // Pointer, word count and slice position; a completing pop frees room for a same-cycle write.
    always_comb begin
        pop         = bus.rd_ena && (count_q != '0);
        word_done   = pop && (slice_idx_q == head_end_idx);
        wr_accept   = bus.wr_ena && ((count_q != DEPTH_CNT) || word_done);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        slice_idx_d = slice_idx_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (word_done) begin
            rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(1);
            slice_idx_d = '0;
        end else if (pop) begin
            slice_idx_d = slice_idx_q + SIW'(1);
        end
        case ({wr_accept, word_done})
            2'b10:   count_d = count_q + (ADDR_WIDTH + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_WIDTH + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            slice_idx_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            slice_idx_q <= slice_idx_d;
        end
    end

    assign bus.wr_full    = (count_q >= FULL_THRESH);
    assign bus.rd_empty   = (count_q == '0);
    assign bus.rd_dat     = head_data[slice_idx_q*DATA_OUT_WIDTH +: DATA_OUT_WIDTH];
    assign bus.rd_last    = head_last && (slice_idx_q == head_end_idx) && (count_q != '0);
    assign bus.rd_dat_cnt = count_q;

endmodule

// File: tb/tb_simple_fifo_downsizer.sv
// tb/tb_simple_fifo_downsizer.sv - randomized and directed bench against a word-queue reference
module tb_simple_fifo_downsizer;

    localparam int RATIO = 8;
    localparam int DEPTH = 16;
    localparam int SLACK = 1;
`ifdef SIMPLE_FIFO_DOWNSIZER_PARTIAL_EN
    localparam bit PARTIAL = 1'b1;
`else
    localparam bit PARTIAL = 1'b0;
`endif

    typedef struct {
        logic [127:0] d;
        bit           l;
        int           n;
    } word_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    simple_fifo_downsizer_if bus ();

    simple_fifo_downsizer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    word_t mq[$];
    int    pos = 0;
    int    n_vec = 0;
    int    n_err = 0;
    int    max_cnt = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int last_slice(input word_t w);
        int n;
        n = RATIO;
        if (PARTIAL && w.l && w.n >= 1 && w.n <= RATIO) n = w.n;
        return n - 1;
    endfunction

    function automatic logic [15:0] slice_of(input logic [127:0] d, input int p);
        logic [127:0] t;
        t = d >> (p * 16);
        return t[15:0];
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_outputs();
        chk("rd_empty", bus.rd_empty, mq.size() == 0);
        chk("rd_dat_cnt", bus.rd_dat_cnt, mq.size());
        chk("wr_full", bus.wr_full, mq.size() >= DEPTH - SLACK);
        if (mq.size() > 0) begin
            chk("rd_dat", bus.rd_dat, slice_of(mq[0].d, pos));
            chk("rd_last", bus.rd_last, mq[0].l && pos == last_slice(mq[0]));
        end else begin
            chk("rd_last_empty", bus.rd_last, 1'b0);
        end
        if (int'(bus.rd_dat_cnt) > max_cnt) max_cnt = int'(bus.rd_dat_cnt);
    endtask

    // One clock: check outputs, drive inputs, advance the model at the edge.
    task automatic step(input bit we, input logic [127:0] wd, input bit wl, input int ns, input bit re);
        word_t w;
        bus.wr_ena  = we;
        bus.wr_dat  = wd;
        bus.wr_last = wl;
`ifdef SIMPLE_FIFO_DOWNSIZER_PARTIAL_EN
        bus.wr_nslices = 4'(ns);
`endif
        bus.rd_ena  = re;
        check_outputs();
        @(posedge clk);
        if (re && mq.size() > 0) begin
            if (pos == last_slice(mq[0])) begin
                void'(mq.pop_front());
                pos = 0;
            end else begin
                pos++;
            end
        end
        if (we && mq.size() < DEPTH) begin
            w.d = wd;
            w.l = wl;
            w.n = ns;
            mq.push_back(w);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        bus.wr_ena = 1'b0;
        bus.rd_ena = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        pos = 0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (mq.size() > 0 && guard < 400) begin
            step(0, '0, 0, 0, 1);
            guard++;
        end
        chk("drain_done", mq.size(), 0);
    endtask

    initial begin
        logic [127:0] pat;
        int last_hits;
        int last_pos;

        bus.wr_ena  = 1'b0;
        bus.wr_dat  = '0;
        bus.wr_last = 1'b0;
        bus.rd_ena  = 1'b0;
`ifdef SIMPLE_FIFO_DOWNSIZER_PARTIAL_EN
        bus.wr_nslices = '0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        chk("reset_empty", bus.rd_empty, 1'b1);
        chk("reset_cnt", bus.rd_dat_cnt, 0);
        chk("reset_full", bus.wr_full, 1'b0);
        chk("reset_last", bus.rd_last, 1'b0);

        // single word, slices 0..7 LSB first
        for (int i = 0; i < RATIO; i++) pat[i*16 +: 16] = 16'(i);
        step(1, pat, 0, 0, 0);
        for (int i = 0; i < RATIO; i++) begin
            chk("single_slice", bus.rd_dat, i);
            chk("single_cnt", bus.rd_dat_cnt, 1);
            step(0, '0, 0, 0, 1);
        end
        chk("single_empty", bus.rd_empty, 1'b1);

        // four-word frame, last on the fourth word
        for (int i = 0; i < 4; i++) step(1, rnd128(), i == 3, 0, 0);
        last_hits = 0;
        last_pos = 0;
        for (int i = 1; i <= 4 * RATIO; i++) begin
            if (bus.rd_last) begin
                last_hits++;
                last_pos = i;
            end
            step(0, '0, 0, 0, 1);
        end
        chk("frame_last_hits", last_hits, 1);
        chk("frame_last_pos", last_pos, 4 * RATIO);

        // fill past capacity
        for (int i = 0; i <= DEPTH; i++) begin
            step(1, 128'(i), 0, 0, 0);
            if (i == DEPTH - 3) chk("fill_not_full_14", bus.wr_full, 1'b0);
            if (i == DEPTH - 2) chk("fill_full_15", bus.wr_full, 1'b1);
        end
        chk("fill_cnt_sat", bus.rd_dat_cnt, DEPTH);
        drain();

        // pop while empty
        step(0, '0, 0, 0, 1);
        step(0, '0, 0, 0, 1);
        chk("empty_pop_cnt", bus.rd_dat_cnt, 0);

        // concurrent streaming
        max_cnt = 0;
        for (int i = 0; i < 32; i++) step(1, rnd128(), ($urandom_range(0, 3) == 0), 0, 1);
        drain();
        chk("stream_max_cnt_ok", max_cnt <= DEPTH, 1'b1);

        // reset in the middle of a word
        step(1, rnd128(), 0, 0, 0);
        step(1, rnd128(), 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, '0, 0, 0, 1);
        do_reset();
        chk("midreset_empty", bus.rd_empty, 1'b1);
        chk("midreset_cnt", bus.rd_dat_cnt, 0);
        step(1, pat, 0, 0, 0);
        chk("midreset_slice0", bus.rd_dat, 0);
        drain();

`ifdef SIMPLE_FIFO_DOWNSIZER_PARTIAL_EN
        // short last word followed by a normal word
        step(1, pat, 1, 3, 0);
        step(1, ~pat, 0, 0, 0);
        step(0, '0, 0, 0, 1);
        step(0, '0, 0, 0, 1);
        chk("partial_last3", bus.rd_last, 1'b1);
        chk("partial_slice2", bus.rd_dat, 2);
        step(0, '0, 0, 0, 1);
        chk("partial_next", bus.rd_dat, 16'hFFFF);
        chk("partial_cnt", bus.rd_dat_cnt, 1);
        drain();
`endif

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 2) == 0), rnd128(), ($urandom_range(0, 3) == 0),
                 int'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
